// File: rtl/mult_acc_if.sv
// Valid-only stream bundle for mult_acc: sample inputs (master drives) and
// registered results (slave drives).
interface mult_acc_if #(
  parameter int A_DATA_WIDTH = 25,
  parameter int B_DATA_WIDTH = 18,
  parameter int C_DATA_WIDTH = 48,
  parameter int P_DATA_WIDTH = 48,
  parameter int CHAN_WIDTH   = 2
);
  logic                           in_valid;
  logic [CHAN_WIDTH-1:0]          in_chan;
  logic                           in_acc;
  logic signed [A_DATA_WIDTH-1:0] a;
  logic signed [B_DATA_WIDTH-1:0] b;
  logic signed [C_DATA_WIDTH-1:0] c;
  logic                           out_valid;
  logic [CHAN_WIDTH-1:0]          out_chan;
  logic signed [P_DATA_WIDTH-1:0] p;
  logic                           overflow;

  modport master (
    output in_valid, in_chan, in_acc, a, b, c,
    input  out_valid, out_chan, p, overflow
  );

  modport slave (
    input  in_valid, in_chan, in_acc, a, b, c,
    output out_valid, out_chan, p, overflow
  );
endinterface

// File: rtl/mult_acc.sv
// Three-stage signed multiply-add/accumulate with one 48-bit accumulator per channel.
// Define MULT_ACC_SATURATE_EN to saturate p and flag overflow instead of wrapping.
module mult_acc #(
  parameter int A_DATA_WIDTH = 25,
  parameter int B_DATA_WIDTH = 18,
  parameter int C_DATA_WIDTH = 48,
  parameter int P_DATA_WIDTH = 48,
  parameter int NUM_CHANNELS = 4,
  parameter int CHAN_WIDTH   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input logic       clk,
  input logic       rst,
  mult_acc_if.slave bus
);
  localparam int MW = A_DATA_WIDTH + B_DATA_WIDTH;

  logic chan_ok;

  // Channel codes past NUM_CHANNELS only exist when NUM_CHANNELS is not a power of two.
  generate
    if ((1 << CHAN_WIDTH) > NUM_CHANNELS) begin : g_chan_chk
      assign chan_ok = (bus.in_chan < CHAN_WIDTH'(NUM_CHANNELS));
    end else begin : g_chan_full
      assign chan_ok = 1'b1;
    end
  endgenerate

  // S1
  logic                           v1_q, v1_d;
  logic [CHAN_WIDTH-1:0]          ch1_q, ch1_d;
  logic                           acc1_q, acc1_d;
  logic signed [A_DATA_WIDTH-1:0] a1_q, a1_d;
  logic signed [B_DATA_WIDTH-1:0] b1_q, b1_d;
  logic signed [47:0]             c1_q, c1_d;
  // S2
  logic                           v2_q, v2_d;
  logic [CHAN_WIDTH-1:0]          ch2_q, ch2_d;
  logic                           acc2_q, acc2_d;
  logic signed [47:0]             m2_q, m2_d;
  logic signed [47:0]             c2_q, c2_d;
  // S3 / outputs
  logic                           out_valid_q, out_valid_d;
  logic [CHAN_WIDTH-1:0]          out_chan_q, out_chan_d;
  logic signed [P_DATA_WIDTH-1:0] p_q, p_d;
  logic signed [47:0]             acc_q [NUM_CHANNELS];
  logic signed [47:0]             acc_d [NUM_CHANNELS];

  logic signed [MW-1:0]           prod;
  logic signed [47:0]             acc_rd;
  logic signed [47:0]             sum;

`ifdef MULT_ACC_SATURATE_EN
  localparam logic [47:0] P_MIN48 = 48'h1 << (P_DATA_WIDTH - 1);
  localparam logic [P_DATA_WIDTH-1:0] P_MIN = P_MIN48[P_DATA_WIDTH-1:0];
  localparam logic [P_DATA_WIDTH-1:0] P_MAX = ~P_MIN;

  logic               overflow_q, overflow_d;
  logic signed [47:0] sum_hi;
`endif

  always_comb begin
    v1_d   = bus.in_valid & chan_ok;
    ch1_d  = bus.in_chan;
    acc1_d = bus.in_acc;
    a1_d   = bus.a;
    b1_d   = bus.b;
    c1_d   = 48'(bus.c);

    prod   = MW'(a1_q) * MW'(b1_q);
    v2_d   = v1_q;
    ch2_d  = ch1_q;
    acc2_d = acc1_q;
    m2_d   = 48'(prod);
    c2_d   = c1_q;

    // Accumulator read and write share S3, so back-to-back same-channel samples chain.
    acc_rd = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (ch2_q == CHAN_WIDTH'(i)) acc_rd = acc_q[i];
    end
    sum = m2_q + (acc2_q ? acc_rd : c2_q);
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      acc_d[i] = (v2_q && (ch2_q == CHAN_WIDTH'(i))) ? sum : acc_q[i];
    end

    out_valid_d = v2_q;
    out_chan_d  = ch2_q;
`ifdef MULT_ACC_SATURATE_EN
    sum_hi     = sum >>> (P_DATA_WIDTH - 1);
    overflow_d = 1'b0;
    p_d        = sum[P_DATA_WIDTH-1:0];
    if (sum_hi != '0 && sum_hi != '1) begin
      overflow_d = 1'b1;
      p_d        = sum[47] ? P_MIN : P_MAX;
    end
`else
    p_d = sum[P_DATA_WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      ch1_q       <= '0;
      acc1_q      <= 1'b0;
      a1_q        <= '0;
      b1_q        <= '0;
      c1_q        <= '0;
      v2_q        <= 1'b0;
      ch2_q       <= '0;
      acc2_q      <= 1'b0;
      m2_q        <= '0;
      c2_q        <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      p_q         <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) acc_q[i] <= '0;
`ifdef MULT_ACC_SATURATE_EN
      overflow_q  <= 1'b0;
`endif
    end else begin
      v1_q        <= v1_d;
      ch1_q       <= ch1_d;
      acc1_q      <= acc1_d;
      a1_q        <= a1_d;
      b1_q        <= b1_d;
      c1_q        <= c1_d;
      v2_q        <= v2_d;
      ch2_q       <= ch2_d;
      acc2_q      <= acc2_d;
      m2_q        <= m2_d;
      c2_q        <= c2_d;
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      p_q         <= p_d;
      for (int i = 0; i < NUM_CHANNELS; i++) acc_q[i] <= acc_d[i];
`ifdef MULT_ACC_SATURATE_EN
      overflow_q  <= overflow_d;
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.p         = p_q;
`ifdef MULT_ACC_SATURATE_EN
  assign bus.overflow  = overflow_q;
`else
  assign bus.overflow  = 1'b0;
`endif
endmodule

// File: tb/tb_mult_acc.sv
// Bench for mult_acc (3 channels, 16-bit p): vector table feeding a scoreboard,
// plus a mid-stream reset sequence. Expectations follow MULT_ACC_SATURATE_EN.
module tb_mult_acc;
  localparam int AW = 25;
  localparam int BW = 18;
  localparam int CW = 48;
  localparam int PW = 16;
  localparam int NC = 3;
  localparam int CHW = 2;
`ifdef MULT_ACC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic              vld;
    logic [CHW-1:0]    ch;
    logic              acc;
    logic signed [AW-1:0] a;
    logic signed [BW-1:0] b;
    logic signed [CW-1:0] c;
    logic              exp_out;
    longint            p_wrap;
    longint            p_sat;
    logic              ovf_sat;
  } vec_t;

  typedef struct {
    logic [CHW-1:0] ch;
    longint         p;
    logic           ovf;
    int             cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_vec;
  int   n_err;
  vec_t vt[$];
  exp_t sb[$];

  mult_acc_if #(.A_DATA_WIDTH(AW), .B_DATA_WIDTH(BW), .C_DATA_WIDTH(CW),
                .P_DATA_WIDTH(PW), .CHAN_WIDTH(CHW)) bus ();

  mult_acc #(.A_DATA_WIDTH(AW), .B_DATA_WIDTH(BW), .C_DATA_WIDTH(CW),
             .P_DATA_WIDTH(PW), .NUM_CHANNELS(NC), .CHAN_WIDTH(CHW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic signed [63:0] act, input logic signed [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic vec_t mk(logic vld, int ch, logic acc, longint a, longint b, longint c,
                              logic eo, longint pw, longint ps, logic os);
    vec_t v;
    v.vld = vld; v.ch = CHW'(ch); v.acc = acc;
    v.a = AW'(a); v.b = BW'(b); v.c = CW'(c);
    v.exp_out = eo; v.p_wrap = pw; v.p_sat = ps; v.ovf_sat = os;
    return v;
  endfunction

  task automatic add(int ch, logic acc, longint a, longint b, longint c, longint p);
    vt.push_back(mk(1'b1, ch, acc, a, b, c, 1'b1, p, p, 1'b0));
  endtask

  task automatic drive(input vec_t v);
    exp_t e;
    @(negedge clk);
    bus.in_valid = v.vld;
    bus.in_chan  = v.ch;
    bus.in_acc   = v.acc;
    bus.a        = v.a;
    bus.b        = v.b;
    bus.c        = v.c;
    if (v.vld && v.exp_out && !rst) begin
      e.ch  = v.ch;
      e.p   = SAT ? v.p_sat : v.p_wrap;
      e.ovf = SAT ? v.ovf_sat : 1'b0;
      e.cyc = cyc + 3;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && sb.size() > 0; i++) @(negedge clk);
    check("drain_pending", sb.size(), 0);
    sb.delete();
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset_state();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_chan", bus.out_chan, 0);
    check("rst_p", bus.p, 0);
    check("rst_overflow", bus.overflow, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out: got out_valid=1 chan=%0d p=%0d, required no output (cycle %0d)",
                 bus.out_chan, bus.p, cyc);
      end else begin
        e = sb.pop_front();
        check("latency", cyc, e.cyc);
        check("out_chan", bus.out_chan, e.ch);
        check("p", bus.p, e.p);
        check("overflow", bus.overflow, e.ovf);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, required finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_chan = '0; bus.in_acc = 1'b0;
    bus.a = '0; bus.b = '0; bus.c = '0;

    // plain multiply-add, then a 5-long accumulation on ch1 (c ignored when accumulating)
    add(0, 0, 3, -4, 5, -7);
    add(1, 0, 2, 3, 0, 6);
    add(1, 1, 2, 3, 999, 12);
    add(1, 1, 2, 3, 999, 18);
    add(1, 1, 2, 3, 999, 24);
    add(1, 1, 2, 3, 999, 30);
    // clear ch0/ch2, then interleave them
    add(0, 0, 0, 0, 0, 0);
    add(2, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 77, 1);
    add(2, 1, 1, 10, 0, 10);
    add(0, 1, 1, 1, 0, 2);
    add(2, 1, 1, 10, 0, 20);
    add(0, 1, 1, 1, 0, 3);
    add(2, 1, 1, 10, 0, 30);
    add(1, 1, 1, 1, 0, 31);
    // two bubbles carrying live-looking data, then an out-of-range channel
    vt.push_back(mk(1'b0, 0, 1'b1, 100, 100, 0, 1'b0, 0, 0, 1'b0));
    vt.push_back(mk(1'b0, 2, 1'b1, 100, 100, 0, 1'b0, 0, 0, 1'b0));
    vt.push_back(mk(1'b1, 3, 1'b0, 5, 5, 7, 1'b0, 0, 0, 1'b0));
    // read back accumulators with a*b = 0
    add(0, 1, 0, 0, 0, 3);
    add(1, 1, 0, 0, 0, 31);
    add(2, 1, 0, 0, 0, 30);
    add(0, 0, -5, 7, -100, -135);
    add(0, 1, -1, -1, 0, -134);
    // extremes: 2^41 product, stored unsaturated, and p-width boundaries
    vt.push_back(mk(1'b1, 0, 1'b0, -16777216, -131072, 0, 1'b1, 0, 32767, 1'b1));
    vt.push_back(mk(1'b1, 0, 1'b1, 0, 0, 0, 1'b1, 0, 32767, 1'b1));
    add(0, 0, 0, 0, 0, 0);
    vt.push_back(mk(1'b1, 1, 1'b0, -16777216, 131071, 0, 1'b1, 0, -32768, 1'b1));
    vt.push_back(mk(1'b1, 2, 1'b0, 0, 0, 32767, 1'b1, 32767, 32767, 1'b0));
    vt.push_back(mk(1'b1, 2, 1'b0, 0, 0, 32768, 1'b1, -32768, 32767, 1'b1));
    vt.push_back(mk(1'b1, 2, 1'b0, 0, 0, -32768, 1'b1, -32768, -32768, 1'b0));
    vt.push_back(mk(1'b1, 2, 1'b0, 0, 0, -32769, 1'b1, 32767, -32768, 1'b1));

    repeat (3) @(negedge clk);
    check_reset_state();
    rst = 1'b0;

    for (int i = 0; i < vt.size(); i++) drive(vt[i]);
    idle();
    drain();

    // three samples launched; reset lands with the third, so none may emerge
    drive(mk(1'b1, 0, 1'b0, 4, 4, 100, 1'b1, 0, 0, 1'b0));
    drive(mk(1'b1, 1, 1'b0, 4, 4, 100, 1'b1, 0, 0, 1'b0));
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.in_chan = 2'd2; bus.in_acc = 1'b0;
    bus.a = 25'sd9; bus.b = 18'sd9; bus.c = 48'sd1;
    @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst_pending", sb.size(), 0);

    vt.delete();
    add(0, 1, 1, 1, 0, 1);
    add(2, 1, 2, 3, 0, 6);
    add(1, 1, 0, 0, 55, 0);
    for (int i = 0; i < vt.size(); i++) drive(vt[i]);
    idle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
